// File: rtl/line_pattern_gen_if.sv
// Stream bundle between the line/frame pattern source and its consumer.
// Ports: enable/mode/ready flow from the consumer side; data/valid/sop/eop,
//        line_idx and frame_done flow from the generator side.
interface line_pattern_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LW         = 3
);
   logic                  enable;
   logic [1:0]            mode;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  sop;
   logic                  eop;
   logic [LW-1:0]         line_idx;
   logic                  frame_done;

   modport master (
      input  enable, mode, ready,
      output data, valid, sop, eop, line_idx, frame_done
   );

   modport slave (
      output enable, mode, ready,
      input  data, valid, sop, eop, line_idx, frame_done
   );
endinterface

// File: rtl/line_pattern_gen.sv
// Line/frame test-pattern source: LINES lines of LINE_SIZE beats with sop/eop framing and idle gaps.
// Latency: first beat (sop) is presented one cycle after enable is seen in IDLE; all outputs registered.
// Backpressure: valid/ready; while valid && !ready the beat, sop and eop hold and no counter advances.
// Ports: clock, reset (sync, active-high); bus (master modport): enable, mode, ready in;
//        data, valid, sop, eop, line_idx, frame_done out.
module line_pattern_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int LINE_SIZE  = 20,
   parameter int LINES      = 5,
   parameter int LINE_GAP   = 4,
   parameter int FRAME_GAP  = 16
) (
   input  logic                clock,
   input  logic                reset,
   line_pattern_gen_if.master  bus
);
   localparam int LW   = (LINES > 2) ? $clog2(LINES) : 1;
   localparam int PW   = (LINE_SIZE > 2) ? $clog2(LINE_SIZE) : 1;
   localparam int GMAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
   // Gap counter is loaded with gap-1, so it never needs to hold GMAX itself.
   localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

   localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_SIZE - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
   localparam logic [GW-1:0] LGAP_LOAD = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
   localparam logic [GW-1:0] FGAP_LOAD = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_LGAP, S_FGAP} state_t;

   state_t                state_q;
   logic [PW-1:0]         pix_q, pix_d;
   logic [LW-1:0]         line_q, line_d;
   logic [GW-1:0]         gap_q;
   logic [1:0]            mode_q, mode_d;
   logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q, sop_q, eop_q, frame_done_q;

   logic accept, line_end, last_line, gap_done, new_frame, new_line;

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            m,
      input logic [PW-1:0]         p,
      input logic [LW-1:0]         l,
      input logic [DATA_WIDTH-1:0] r
   );
      case (m)
         2'd0:    return r;
         2'd1:    return DATA_WIDTH'(p);
         2'd2:    return DATA_WIDTH'(l);
         default: return {DATA_WIDTH{p[0] ^ l[0]}};
      endcase
   endfunction

   always_comb begin
      accept    = valid_q && bus.ready;
      // RAMP value of the next beat to present; it tracks every accepted beat.
      ramp_d    = accept ? ramp_q + 1'b1 : ramp_q;
      pix_d     = pix_q + 1'b1;
      line_end  = (state_q == S_LINE) && accept && eop_q;
      last_line = (line_q == LINE_LAST);
      gap_done  = (gap_q == '0);
      // A zero-length gap starts the next line/frame on the eop acceptance edge itself.
      new_frame = bus.enable && ((state_q == S_IDLE) ||
                                 (state_q == S_FGAP && gap_done) ||
                                 (FRAME_GAP == 0 && line_end && last_line));
      new_line  = (state_q == S_LGAP && gap_done) ||
                  (LINE_GAP == 0 && line_end && !last_line);
      mode_d    = new_frame ? bus.mode : mode_q;
      line_d    = new_frame ? '0 : (new_line ? line_q + 1'b1 : line_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pix_q        <= '0;
         line_q       <= '0;
         gap_q        <= '0;
         mode_q       <= '0;
         ramp_q       <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         line_q       <= line_d;
         ramp_q       <= ramp_d;
         frame_done_q <= line_end && last_line;
         if (new_frame || new_line) begin
            state_q <= S_LINE;
            pix_q   <= '0;
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            data_q  <= pattern(mode_d, '0, line_d, ramp_d);
         end else begin
            case (state_q)
               S_LINE: begin
                  if (accept) begin
                     if (!eop_q) begin
                        pix_q  <= pix_d;
                        sop_q  <= 1'b0;
                        eop_q  <= (pix_d == PIX_LAST);
                        data_q <= pattern(mode_q, pix_d, line_q, ramp_d);
                     end else begin
                        valid_q <= 1'b0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                        if (!last_line) begin
                           state_q <= S_LGAP;
                           gap_q   <= LGAP_LOAD;
                        end else if (FRAME_GAP != 0) begin
                           state_q <= S_FGAP;
                           gap_q   <= FGAP_LOAD;
                        end else begin
                           state_q <= S_IDLE;
                        end
                     end
                  end
               end
               // A finished LGAP always takes the new_line path, so reaching
               // gap_done here means frame gap over with enable low.
               S_LGAP, S_FGAP: begin
                  if (gap_done) state_q <= S_IDLE;
                  else          gap_q   <= gap_q - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.data       = data_q;
   assign bus.valid      = valid_q;
   assign bus.sop        = sop_q;
   assign bus.eop        = eop_q;
   assign bus.line_idx   = line_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_line_pattern_gen.sv
module tb_line_pattern_gen;
   localparam int LS = 20;
   localparam int NL = 5;

   logic       clk = 1'b0;
   logic       rst_r = 1'b1;
   logic       en_r = 1'b0;
   logic [1:0] mode_r = 2'd0;
   logic       rdy_r = 1'b1;
   logic       sel = 1'b0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   line_pattern_gen_if #(.DATA_WIDTH(8), .LW(3)) ifa ();
   line_pattern_gen_if #(.DATA_WIDTH(8), .LW(3)) ifb ();

   assign ifa.enable = en_r;
   assign ifa.mode   = mode_r;
   assign ifa.ready  = rdy_r;
   assign ifb.enable = en_r;
   assign ifb.mode   = mode_r;
   assign ifb.ready  = rdy_r;

   line_pattern_gen dut_a (.clock(clk), .reset(rst_r), .bus(ifa.master));

   line_pattern_gen #(.DATA_WIDTH(8), .LINE_SIZE(LS), .LINES(NL), .LINE_GAP(0), .FRAME_GAP(0))
      dut_b (.clock(clk), .reset(rst_r), .bus(ifb.master));

   logic [7:0] o_data;
   logic [2:0] o_li;
   logic       o_valid, o_sop, o_eop, o_fd;
   assign o_data  = sel ? ifb.data       : ifa.data;
   assign o_li    = sel ? ifb.line_idx   : ifa.line_idx;
   assign o_valid = sel ? ifb.valid      : ifa.valid;
   assign o_sop   = sel ? ifb.sop        : ifa.sop;
   assign o_eop   = sel ? ifb.eop        : ifa.eop;
   assign o_fd    = sel ? ifb.frame_done : ifa.frame_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_data(input int md, input int p, input int l, input int r);
      case (md)
         0:       return r[7:0];
         1:       return p[7:0];
         2:       return l[7:0];
         default: return (((p ^ l) & 1) != 0) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 32'(0));
      chk({tag, "_data"},  32'(o_data),  32'(0));
      chk({tag, "_sop"},   32'(o_sop),   32'(0));
      chk({tag, "_eop"},   32'(o_eop),   32'(0));
      chk({tag, "_line"},  32'(o_li),    32'(0));
      chk({tag, "_fdone"}, 32'(o_fd),    32'(0));
   endtask

   // Entered on the cycle the first beat of a frame is shown, ready held high.
   // Checks every beat and every gap cycle; leaves on the cycle after the frame gap.
   task automatic run_frame(input int lg, input int fg, input int md, input int rbase,
                            input int fd_first, input int chg_at, input int chg_md,
                            input int dis_at);
      int b = 0;
      for (int l = 0; l < NL; l++) begin
         for (int p = 0; p < LS; p++) begin
            chk("beat_valid", 32'(o_valid), 32'(1));
            chk("beat_data",  32'(o_data),  32'(exp_data(md, p, l, rbase + b)));
            chk("beat_sop",   32'(o_sop),   32'(p == 0));
            chk("beat_eop",   32'(o_eop),   32'(p == LS - 1));
            if (p == 0) chk("line_idx", 32'(o_li), 32'(l));
            if (l == 0 && p == 0) chk("fdone_at_sop", 32'(o_fd), 32'(fd_first));
            if (b == chg_at) mode_r = chg_md[1:0];
            if (b == dis_at) en_r = 1'b0;
            b++;
            tick();
         end
         for (int g = 0; g < ((l < NL - 1) ? lg : fg); g++) begin
            chk("gap_valid", 32'(o_valid), 32'(0));
            if (l == NL - 1) chk("gap_fdone", 32'(o_fd), 32'(g == 0));
            tick();
         end
      end
   endtask

   task automatic do_reset();
      rst_r = 1'b1;
      en_r  = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int beats, cyc, p, l;
      logic held;

      // Reset state, then defaults in RAMP mode.
      sel = 1'b0;
      do_reset();
      chk_reset_vals("rst");
      rst_r = 1'b0; en_r = 1'b1; mode_r = 2'd0; rdy_r = 1'b1;
      tick();
      chk("start_valid", 32'(o_valid), 32'(1));
      chk("start_sop",   32'(o_sop),   32'(1));
      chk("start_data",  32'(o_data),  32'(0));
      // Frames 1-3 RAMP (wraps inside frame 3); mode change in frame 3 lands in frame 4.
      run_frame(4, 16, 0, 0,   0, -1, 0, -1);
      run_frame(4, 16, 0, 100, 0, -1, 0, -1);
      run_frame(4, 16, 0, 200, 0, 30, 2, -1);
      // Frame 4 LINE_ID; enable dropped at beat 30 still lets it finish.
      run_frame(4, 16, 2, 0,   0, -1, 0, 30);
      for (int i = 0; i < 10; i++) begin
         chk("idle_valid", 32'(o_valid), 32'(0));
         tick();
      end

      // Backpressure in LINE_RAMP mode.
      do_reset();
      chk_reset_vals("rst2");
      rst_r = 1'b0; en_r = 1'b1; mode_r = 2'd1;
      tick();
      beats = 0; cyc = 0; p = 0; l = 0; held = 1'b0;
      while (beats < NL * LS && cyc < 2000) begin
         rdy_r = 1'($urandom_range(0, 1));
         if (held) chk("bp_hold_valid", 32'(o_valid), 32'(1));
         if (o_valid) begin
            chk("bp_data", 32'(o_data), 32'(p));
            chk("bp_sop",  32'(o_sop),  32'(p == 0));
            chk("bp_eop",  32'(o_eop),  32'(p == LS - 1));
            chk("bp_line", 32'(o_li),   32'(l));
            if (rdy_r) begin
               beats++;
               p++;
               if (p == LS) begin p = 0; l++; end
            end
         end
         held = o_valid && !rdy_r;
         tick();
         cyc++;
      end
      chk("bp_beats", 32'(beats), 32'(NL * LS));
      rdy_r = 1'b1;

      // Zero gaps with CHECKER on the second instance.
      sel = 1'b1;
      do_reset();
      chk_reset_vals("rst3");
      rst_r = 1'b0; en_r = 1'b1; mode_r = 2'd3;
      tick();
      run_frame(0, 0, 3, 0, 0, -1, 0, -1);
      run_frame(0, 0, 3, 0, 1, -1, 0, -1);

      // Reset in the middle of line 2.
      sel = 1'b0;
      do_reset();
      rst_r = 1'b0; en_r = 1'b1; mode_r = 2'd0;
      tick();
      beats = 0; cyc = 0;
      while (beats < 45 && cyc < 500) begin
         if (o_valid) beats++;
         tick();
         cyc++;
      end
      chk("pre_rst_data", 32'(o_data), 32'(45));
      rst_r = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(o_valid), 32'(0));
      chk("mid_rst_line",  32'(o_li),    32'(0));
      chk("mid_rst_data",  32'(o_data),  32'(0));
      chk("mid_rst_sop",   32'(o_sop),   32'(0));
      rst_r = 1'b0;
      tick();
      chk("restart_valid", 32'(o_valid), 32'(1));
      chk("restart_sop",   32'(o_sop),   32'(1));
      chk("restart_data",  32'(o_data),  32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end
endmodule
